// File: rtl/wb_data_master_if.sv
// Wishbone classic master bridging the CPU MEM-stage load/store port to the
// data-side bus. One CPU request becomes one registered bus cycle; the
// pipeline is held via stallreq_o until the cycle acks, times out or is
// flushed. Load data is parked in rd_buf while the pipeline is stalled by
// some other source, so the CPU can still pick it up afterwards.
module wb_data_master_if #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    // CPU MEM-stage side
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,

    // Pipeline control
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        err_o,

    // Wishbone master side
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_t;

    state_t              state_reg;
    logic [TO_WIDTH-1:0] count_reg;
    logic [31:0]         rd_buf_reg;

    // A new request is only taken when it is not being flushed away.
    logic start_req;
    assign start_req = cpu_ce_i & ~flush_i;

    // Timeout detection; a zero TIMEOUT_CYCLES removes the watchdog entirely
    // so a slow slave may hold the bus indefinitely.
    logic timeout_hit;
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            localparam logic [TO_WIDTH-1:0] COUNT_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
            assign timeout_hit = (count_reg == COUNT_LAST);
        end
    endgenerate

    // Control FSM: launches the bus cycle, holds it stable, and retires it
    // on flush, ack or timeout (in that priority order).
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            rd_buf_reg <= '0;
            err_o      <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_cyc_o   <= 1'b0;
        end else begin
            // err_o is a single-cycle pulse; only the timeout branch raises it.
            err_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_req) begin
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        wb_adr_o   <= cpu_addr_i;
                        wb_dat_o   <= cpu_data_i;
                        wb_sel_o   <= cpu_sel_i;
                        wb_we_o    <= cpu_we_i;
                        count_reg  <= '0;
                        rd_buf_reg <= '0;
                        state_reg  <= BUSY;
                    end
                end

                BUSY: begin
                    if (flush_i) begin
                        // Abandon the cycle; a write acked right now is
                        // already committed at the slave, nothing to undo.
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_adr_o  <= '0;
                        wb_dat_o  <= '0;
                        wb_sel_o  <= '0;
                        wb_we_o   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_adr_o  <= '0;
                        wb_dat_o  <= '0;
                        wb_sel_o  <= '0;
                        wb_we_o   <= 1'b0;
                        if (!wb_we_o) begin
                            rd_buf_reg <= wb_dat_i;
                        end
                        state_reg <= stall_i ? WAIT_STALL : IDLE;
                    end else if (timeout_hit) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        wb_adr_o   <= '0;
                        wb_dat_o   <= '0;
                        wb_sel_o   <= '0;
                        wb_we_o    <= 1'b0;
                        err_o      <= 1'b1;
                        rd_buf_reg <= '0;
                        state_reg  <= stall_i ? WAIT_STALL : IDLE;
                    end else begin
                        // Bus outputs simply hold; only the watchdog advances.
                        count_reg <= count_reg + 1'b1;
                    end
                end

                WAIT_STALL: begin
                    // No new request here: the CPU has already consumed the
                    // stall release and must re-present after IDLE.
                    if (!stall_i || flush_i) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Pipeline-facing decode: stall while a request is pending or in flight,
    // and forward load data on the ack cycle or from the parking buffer.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        case (state_reg)
            IDLE: begin
                stallreq_o = start_req;
            end
            BUSY: begin
                if (flush_i) begin
                    stallreq_o = 1'b0;
                end else if (wb_ack_i) begin
                    stallreq_o = 1'b0;
                    cpu_data_o = wb_we_o ? 32'd0 : wb_dat_i;
                end else if (timeout_hit) begin
                    stallreq_o = 1'b0;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            WAIT_STALL: begin
                cpu_data_o = rd_buf_reg;
            end
            default: begin
                stallreq_o = 1'b0;
                cpu_data_o = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_data_master_if.sv
// Directed bench for wb_data_master_if: a per-cycle vector table with
// hand-computed expectations, followed by reset-related hand sequences.
module tb_wb_data_master_if;

    logic        clk;
    logic        rst_n;
    logic        cpu_ce, cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall, flush, stallreq, err;
    logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_stb, wb_cyc, wb_ack;

    int n_cmp = 0;
    int n_bad = 0;

    wb_data_master_if #(
        .TIMEOUT_CYCLES (4),
        .TO_WIDTH       (8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .cpu_ce_i   (cpu_ce),
        .cpu_we_i   (cpu_we),
        .cpu_addr_i (cpu_addr),
        .cpu_sel_i  (cpu_sel),
        .cpu_data_i (cpu_wdata),
        .cpu_data_o (cpu_rdata),
        .stall_i    (stall),
        .flush_i    (flush),
        .stallreq_o (stallreq),
        .err_o      (err),
        .wb_adr_o   (wb_adr),
        .wb_dat_o   (wb_dat_w),
        .wb_sel_o   (wb_sel),
        .wb_we_o    (wb_we),
        .wb_stb_o   (wb_stb),
        .wb_cyc_o   (wb_cyc),
        .wb_dat_i   (wb_dat_r),
        .wb_ack_i   (wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce, we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        stall, flush, ack;
        logic [31:0] rdat;
        logic        x_stallreq;
        logic [31:0] x_data;
        logic        x_cyc, x_we;
        logic [31:0] x_adr, x_dat;
        logic [3:0]  x_sel;
        logic        x_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ce, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wdat,
                       input logic st, input logic fl, input logic ack,
                       input logic [31:0] rdat, input logic xs, input logic [31:0] xd,
                       input logic xc, input logic xw, input logic [31:0] xa,
                       input logic [31:0] xdat, input logic [3:0] xsel, input logic xe);
        vec_t v;
        v.ce = ce; v.we = we; v.addr = addr; v.sel = sel; v.wdat = wdat;
        v.stall = st; v.flush = fl; v.ack = ack; v.rdat = rdat;
        v.x_stallreq = xs; v.x_data = xd; v.x_cyc = xc; v.x_we = xw;
        v.x_adr = xa; v.x_dat = xdat; v.x_sel = xsel; v.x_err = xe;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cpu_ce = v.ce; cpu_we = v.we; cpu_addr = v.addr; cpu_sel = v.sel;
        cpu_wdata = v.wdat; stall = v.stall; flush = v.flush;
        wb_ack = v.ack; wb_dat_r = v.rdat;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_ce = 0; cpu_we = 0; cpu_addr = 0; cpu_sel = 0; cpu_wdata = 0;
        stall = 0; flush = 0; wb_ack = 0; wb_dat_r = 0;

        //   ce we addr         sel   wdat          st fl ak rdat         | stq data         cyc we adr        dat          sel   err
        // Load 0x10, ack on first BUSY cycle
        add(1, 0, 32'h10,       4'hF, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(1, 0, 32'h10,       4'hF, 32'h0,        0, 0, 1, 32'h12345678, 0, 32'h12345678, 1, 0, 32'h10,    32'h0,        4'hF, 0);
        add(0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        // Store, ack after three waiting BUSY cycles; CPU inputs wander meanwhile
        add(1, 1, 32'h20,       4'h3, 32'hCAFEBABE, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(1, 1, 32'h20,       4'h3, 32'hCAFEBABE, 0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 32'h20,    32'hCAFEBABE, 4'h3, 0);
        add(1, 0, 32'h99,       4'hC, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 32'h20,    32'hCAFEBABE, 4'h3, 0);
        add(1, 1, 32'h20,       4'h3, 32'hCAFEBABE, 0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 32'h20,    32'hCAFEBABE, 4'h3, 0);
        add(1, 1, 32'h20,       4'h3, 32'hCAFEBABE, 0, 0, 1, 32'h55555555, 0, 32'h0,        1, 1, 32'h20,    32'hCAFEBABE, 4'h3, 0);
        add(0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        // Load acked while pipeline stalled elsewhere -> WAIT_STALL
        add(1, 0, 32'h44,       4'hF, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(1, 0, 32'h44,       4'hF, 32'h0,        1, 0, 1, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 1, 0, 32'h44,    32'h0,        4'hF, 0);
        add(1, 0, 32'h48,       4'hF, 32'h0,        1, 0, 0, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(1, 0, 32'h48,       4'hF, 32'h0,        1, 0, 1, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 32'hA5A5A5A5, 0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        // No ack: timeout on the 4th BUSY cycle, err pulse one cycle
        add(1, 0, 32'h80,       4'hF, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(1, 0, 32'h80,       4'hF, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        1, 0, 32'h80,    32'h0,        4'hF, 0);
        add(1, 0, 32'h80,       4'hF, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        1, 0, 32'h80,    32'h0,        4'hF, 0);
        add(1, 0, 32'h80,       4'hF, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        1, 0, 32'h80,    32'h0,        4'hF, 0);
        add(1, 0, 32'h80,       4'hF, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h80,    32'h0,        4'hF, 0);
        add(0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 1);
        add(0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        // Flush in the 2nd BUSY cycle, then a fresh load
        add(1, 0, 32'h90,       4'hF, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(1, 0, 32'h90,       4'hF, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        1, 0, 32'h90,    32'h0,        4'hF, 0);
        add(0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h90,    32'h0,        4'hF, 0);
        add(0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(1, 0, 32'h14,       4'h6, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(1, 0, 32'h14,       4'h6, 32'h0,        0, 0, 1, 32'h0BADF00D, 0, 32'h0BADF00D, 1, 0, 32'h14,    32'h0,        4'h6, 0);
        // Flushed request in IDLE is not taken; stray ack in IDLE is ignored
        add(1, 1, 32'hF0,       4'hF, 32'h1,        0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 1, 32'hFFFFFFFF, 0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);
        add(0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0);

        // Reset state, before any clock edge has been seen with reset released
        #3;
        chk("rst_cyc", -1, {31'd0, wb_cyc}, 32'd0);
        chk("rst_stb", -1, {31'd0, wb_stb}, 32'd0);
        chk("rst_adr", -1, wb_adr, 32'd0);
        chk("rst_err", -1, {31'd0, err}, 32'd0);
        chk("rst_stallreq", -1, {31'd0, stallreq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("stallreq", i, {31'd0, stallreq}, {31'd0, vecs[i].x_stallreq});
            chk("cpu_data", i, cpu_rdata, vecs[i].x_data);
            chk("cyc", i, {31'd0, wb_cyc}, {31'd0, vecs[i].x_cyc});
            chk("stb", i, {31'd0, wb_stb}, {31'd0, vecs[i].x_cyc});
            chk("we", i, {31'd0, wb_we}, {31'd0, vecs[i].x_we});
            chk("adr", i, wb_adr, vecs[i].x_adr);
            chk("wdat", i, wb_dat_w, vecs[i].x_dat);
            chk("sel", i, {28'd0, wb_sel}, {28'd0, vecs[i].x_sel});
            chk("err", i, {31'd0, err}, {31'd0, vecs[i].x_err});
            $display("step %0d: ce=%b we=%b ack=%b stall=%b flush=%b -> stallreq=%b data=%h cyc=%b adr=%h err=%b",
                     i, vecs[i].ce, vecs[i].we, vecs[i].ack, vecs[i].stall, vecs[i].flush,
                     stallreq, cpu_rdata, wb_cyc, wb_adr, err);
        end

        // Asynchronous reset in the middle of a BUSY cycle
        @(negedge clk);
        cpu_ce = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_sel = 4'hF; cpu_wdata = 32'h77;
        stall = 0; flush = 0; wb_ack = 0; wb_dat_r = 0;
        @(negedge clk);
        #1;
        chk("arst_busy_cyc", 100, {31'd0, wb_cyc}, 32'd1);
        #1;
        cpu_ce = 0;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", 100, {31'd0, wb_cyc}, 32'd0);
        chk("arst_stb", 100, {31'd0, wb_stb}, 32'd0);
        chk("arst_we", 100, {31'd0, wb_we}, 32'd0);
        chk("arst_adr", 100, wb_adr, 32'd0);
        chk("arst_wdat", 100, wb_dat_w, 32'd0);
        chk("arst_err", 100, {31'd0, err}, 32'd0);
        chk("arst_stallreq", 100, {31'd0, stallreq}, 32'd0);
        $display("async reset: cyc=%b stb=%b adr=%h err=%b", wb_cyc, wb_stb, wb_adr, err);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE takes a fresh load after release
        @(negedge clk);
        cpu_ce = 1; cpu_we = 0; cpu_addr = 32'h34; cpu_sel = 4'hF;
        #1;
        chk("post_rst_stallreq", 101, {31'd0, stallreq}, 32'd1);
        @(negedge clk);
        wb_ack = 1; wb_dat_r = 32'h600DCAFE;
        #1;
        chk("post_rst_cyc", 101, {31'd0, wb_cyc}, 32'd1);
        chk("post_rst_adr", 101, wb_adr, 32'h34);
        chk("post_rst_data", 101, cpu_rdata, 32'h600DCAFE);
        chk("post_rst_stallreq_ack", 101, {31'd0, stallreq}, 32'd0);
        @(negedge clk);
        cpu_ce = 0; wb_ack = 0; wb_dat_r = 0;
        #1;
        chk("post_rst_cyc_drop", 101, {31'd0, wb_cyc}, 32'd0);
        $display("post-reset load: data=600dcafe expected, cyc now %b", wb_cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_data_master_if.md
Name: wb_data_master_if

Overview:
- Wishbone master bridge between the CPU MEM-stage load/store port and the data-side Wishbone bus; the on-chip BRAM slave sits directly downstream.
- Turns a single-cycle CPU memory request into one registered Wishbone classic cycle.
- Holds the pipeline via stallreq_o until ack, timeout or flush.
- Buffers load data while the pipeline is stalled by other causes.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without ack before abort; 0 disables the timeout.
- TO_WIDTH, 8: width of the timeout counter; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-low reset
- cpu_ce_i  in  1  CPU memory request valid
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address
- cpu_sel_i  in  4  byte lane enables
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data to CPU
- stall_i  in  1  pipeline stalled by another source
- flush_i  in  1  pipeline flush (exception)
- stallreq_o  out  1  stall request to pipeline control
- err_o  out  1  one-cycle timeout error pulse
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  Wishbone byte selects
- wb_we_o  out  1  Wishbone write enable
- wb_stb_o  out  1  Wishbone strobe
- wb_cyc_o  out  1  Wishbone cycle
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - state=IDLE; all wb_* outputs 0; rd_buf=0; timeout counter=0; err_o=0.
- Registered outputs: all wb_* outputs, err_o, rd_buf and the counter.
- Combinational outputs: stallreq_o and cpu_data_o, decoded from state and inputs.

State IDLE:
- Start condition: cpu_ce_i=1 and flush_i=0.
  - Next edge: wb_cyc_o=wb_stb_o=1; wb_adr_o=cpu_addr_i; wb_dat_o=cpu_data_i; wb_sel_o=cpu_sel_i; wb_we_o=cpu_we_i.
  - Also next edge: counter=0, rd_buf=0, go to BUSY.
- stallreq_o = cpu_ce_i & ~flush_i.
- cpu_data_o = 0.

State BUSY (priority flush > ack > timeout):
- flush_i=1:
  - Next edge: all wb_* = 0, go to IDLE.
  - stallreq_o=0, cpu_data_o=0.
  - A write acked in this same cycle is committed at the slave; no data is returned.
- wb_ack_i=1:
  - Next edge: all wb_* = 0.
  - On a load, rd_buf<=wb_dat_i.
  - Go to WAIT_STALL if stall_i=1, else IDLE.
  - Same cycle: stallreq_o=0; cpu_data_o = wb_dat_i on a load, 0 on a store.
- Timeout (TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 with no ack):
  - Next edge: all wb_* = 0, err_o=1 for exactly one cycle, rd_buf=0.
  - Go to WAIT_STALL if stall_i=1, else IDLE.
  - Same cycle: stallreq_o=0, cpu_data_o=0.
- Otherwise: counter++, stallreq_o=1, cpu_data_o=0, Wishbone outputs held stable.

State WAIT_STALL:
- stallreq_o=0; cpu_data_o=rd_buf.
- Return to IDLE when stall_i=0 or flush_i=1. No new request is accepted in this state.

Timing and protocol rules:
- With the BRAM slave (ack = cyc & stb, same cycle), minimum latency is 2 cycles: request cycle plus one BUSY cycle with ack.
- stb/cyc never toggle mid-transaction. Address, data, sel and we are constant while cyc=1.
- wb_ack_i is ignored outside BUSY.
- A request arriving in the same cycle the previous one completes is not accepted until the FSM is back in IDLE. The CPU holds cpu_ce_i because stallreq_o stays high in IDLE.

Test Plan:
- Load 0x0000_0010, slave acks on first BUSY cycle with 0x1234_5678:
  - Cycle 1: cyc/stb=1, we=0, adr=0x10.
  - Same cycle: cpu_data_o=0x1234_5678 and stallreq_o falls.
  - Cycle 2: cyc=0.
- Store 0xCAFE_BABE, sel=4'b0011, ack delayed 3 cycles:
  - stallreq_o high for 4 cycles; wb_* stable throughout.
  - we=1, sel=0011.
  - cyc drops the edge after ack.
- Load acked with 0xA5A5_A5A5 while stall_i=1 for 3 more cycles:
  - FSM enters WAIT_STALL; cpu_data_o=0xA5A5_A5A5 each stalled cycle.
  - Returns to IDLE when stall_i falls.
- No ack, TIMEOUT_CYCLES=4:
  - After 4 BUSY cycles cyc/stb drop.
  - err_o pulses exactly 1 cycle; cpu_data_o=0; stallreq_o released.
- flush_i asserted in the 2nd BUSY cycle:
  - Next edge all wb_*=0, FSM in IDLE, err_o=0.
  - Then a fresh load proceeds normally.
- wb_rst_i pulsed low asynchronously mid-BUSY:
  - All wb_* outputs and err_o go to 0 immediately (without waiting for a clock edge).
  - After release, IDLE accepts a new request.
